// File: rtl/spi_pkg.sv
// Shared SPI definitions used by spi_slave and spi_master.
package spi_pkg;

  localparam int unsigned SPI_WIDTH       = 8;
  localparam int unsigned SPI_SYNC_STAGES = 2;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one async pin, with rise/fall detection
// against a one-cycle-delayed copy of the synchronized level.
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = STAGES'({sync_q, din});
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_c = sync_q[STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Byte-oriented SPI target oversampling sck/ss/mosi on the system clock;
// supports all CPOL/CPHA modes and back-to-back bytes within one frame.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH       = SPI_WIDTH,
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             sck,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_byte,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_byte,
  output logic             rx_valid,
  output logic             busy,
  output logic             underrun
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic sck_rise_c, sck_fall_c, ss_rise_c, ss_fall_c;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .din(sck), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .din(ss), .rise_c(ss_rise_c), .fall_c(ss_fall_c)
  );

  assign mosi_sync_d = SYNC_STAGES'({mosi_sync_q, mosi});
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

  state_t           state_q, state_d;
  spi_mode_t        mode_q, mode_d;
  logic [WIDTH-1:0] shift_tx_q, shift_tx_d, shift_rx_q, shift_rx_d;
  logic [WIDTH-1:0] buf_q, buf_d, rx_byte_q, rx_byte_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             skip_q, skip_d, reload_q, reload_d;
  logic             tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d;
  logic             underrun_q, underrun_d, busy_q, busy_d, miso_q, miso_d;
  logic             lead_c, trail_c, sample_c, shift_c, consume_c;
  logic [WIDTH-1:0] tx_next_c;

  // Edge roles follow the mode latched while idle, not the live pins.
  assign lead_c    = mode_q.cpol ? sck_fall_c : sck_rise_c;
  assign trail_c   = mode_q.cpol ? sck_rise_c : sck_fall_c;
  assign sample_c  = mode_q.cpha ? trail_c : lead_c;
  assign shift_c   = mode_q.cpha ? lead_c : trail_c;
  assign tx_next_c = tx_ready_q ? '0 : buf_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    bit_cnt_d  = bit_cnt_q;
    skip_d     = skip_q;
    reload_d   = reload_q;
    buf_d      = buf_q;
    tx_ready_d = tx_ready_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    consume_c  = 1'b0;

    case (state_q)
      IDLE: begin
        mode_d = '{cpol: cpol, cpha: cpha};
        if (ss_fall_c) begin
          state_d    = ACTIVE;
          shift_tx_d = tx_next_c;
          consume_c  = 1'b1;
          bit_cnt_d  = '0;
          skip_d     = mode_q.cpha;
          reload_d   = 1'b0;
        end
      end
      ACTIVE: begin
        if (ss_rise_c) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else if (sample_c) begin
          shift_rx_d = WIDTH'({shift_rx_q, mosi_s});
          if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
            rx_byte_d  = shift_rx_d;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            reload_d   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (shift_c) begin
          if (skip_q) begin
            skip_d = 1'b0;
          end else if (reload_q) begin
            shift_tx_d = tx_next_c;
            consume_c  = 1'b1;
            reload_d   = 1'b0;
          end else begin
            shift_tx_d = WIDTH'({shift_tx_q, 1'b0});
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A consume reads the old buffer; a same-cycle load still lands.
    if (consume_c) begin
      underrun_d = tx_ready_q;
      tx_ready_d = 1'b1;
    end
    if (tx_load && (tx_ready_q || consume_c)) begin
      buf_d      = tx_byte;
      tx_ready_d = 1'b0;
    end

    busy_d = (state_d == ACTIVE);
    miso_d = busy_d & shift_tx_d[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      mode_q      <= '0;
      shift_tx_q  <= '0;
      shift_rx_q  <= '0;
      bit_cnt_q   <= '0;
      skip_q      <= 1'b0;
      reload_q    <= 1'b0;
      buf_q       <= '0;
      tx_ready_q  <= 1'b1;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      busy_q      <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      mode_q      <= mode_d;
      shift_tx_q  <= shift_tx_d;
      shift_rx_q  <= shift_rx_d;
      bit_cnt_q   <= bit_cnt_d;
      skip_q      <= skip_d;
      reload_q    <= reload_d;
      buf_q       <= buf_d;
      tx_ready_q  <= tx_ready_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      busy_q      <= busy_d;
      miso_q      <= miso_d;
    end
  end

  assign miso     = miso_q;
  assign tx_ready = tx_ready_q;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bench-side SPI master plus a per-cycle
// checker that derives busy/miso/rx_valid timing from the pin event times.
module tb_spi_slave;

  localparam int H   = 6;  // clk cycles per sck phase
  localparam int LAT = 3;  // pin-to-action latency in clk cycles

  logic       clk = 1'b0, rst = 1'b1;
  logic       cpol = 1'b0, cpha = 1'b0, sck = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_load = 1'b0;
  logic       miso, tx_ready, rx_valid, busy, underrun;
  logic [7:0] rx_byte;

  spi_slave dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sck(sck), .ss(ss),
    .mosi(mosi), .miso(miso), .tx_byte(tx_byte), .tx_load(tx_load),
    .tx_ready(tx_ready), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int fall_cyc = 0, rise_cyc = 0, last_sample_cyc = -100, last_shift_cyc = -100;
  bit have_fall = 1'b0, in_rst = 1'b1;
  int rxv_count = 0, urun_count = 0;
  logic [7:0] rx_seen[$];
  logic prev_busy = 1'b0, prev_miso = 1'b0, prev_rxv = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle model: every visible action trails its pin event by LAT cycles.
  always @(negedge clk) begin
    logic exp_busy;
    exp_busy = !in_rst && have_fall && (cyc - fall_cyc >= LAT) &&
               !(rise_cyc > fall_cyc && cyc - rise_cyc >= LAT);
    check("busy", busy, exp_busy);
    if (!busy) check("miso_unselected", miso, 1'b0);
    if (busy && prev_busy && miso !== prev_miso)
      check("miso_change_latency", cyc - last_shift_cyc, LAT);
    if (rx_valid) begin
      rxv_count++;
      rx_seen.push_back(rx_byte);
      check("rx_valid_latency", cyc - last_sample_cyc, LAT);
      check("rx_valid_pulse", prev_rxv, 1'b0);
    end
    if (underrun) urun_count++;
    prev_busy = busy;
    prev_miso = miso;
    prev_rxv  = rx_valid;
  end

  function automatic int exp_underruns(input bit pha, input int nbytes, input int loads);
    // With cpha=0 the final trailing edge preloads one extra byte.
    int consumes;
    consumes = 1 + (pha ? nbytes - 1 : nbytes);
    return (consumes > loads) ? consumes - loads : 0;
  endfunction

  task automatic clear_obs();
    rxv_count  = 0;
    urun_count = 0;
    rx_seen.delete();
  endtask

  task automatic load_byte(input logic [7:0] b);
    @(negedge clk);
    tx_byte = b;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic wait_ready_and_load(input logic [7:0] b);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      if (tx_ready) seen = 1'b1;
    end
    check("tx_ready_rise_wait", seen, 1'b1);
    if (seen) load_byte(b);
  endtask

  // Bench master: stream is MSB-first from mo[15], received bits land in mi.
  task automatic do_frame(input bit pol, input bit pha, input int nbits,
                          input logic [15:0] mo, input bit keep_ss,
                          input bit mid_load, input logic [7:0] mid_byte,
                          output logic [15:0] mi);
    mi = '0;
    @(negedge clk);
    cpol = pol;
    cpha = pha;
    sck  = pol;
    repeat (H) @(negedge clk);
    mosi      = pha ? 1'b0 : mo[15];
    ss        = 1'b0;
    fall_cyc  = cyc;
    have_fall = 1'b1;
    if (mid_load) begin
      // lands on the same clk as the frame-start consume
      repeat (LAT - 1) @(negedge clk);
      tx_byte = mid_byte;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      repeat (H - LAT) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
    for (int i = 0; i < nbits; i++) begin
      if (!pha) begin
        mi[15-i] = miso;
        last_sample_cyc = cyc;
      end else begin
        last_shift_cyc = cyc;
        mosi = mo[15-i];
      end
      sck = ~pol;
      repeat (H) @(negedge clk);
      if (!pha) begin
        last_shift_cyc = cyc;
        if (i < 15) mosi = mo[14-i];
      end else begin
        mi[15-i] = miso;
        last_sample_cyc = cyc;
      end
      sck = pol;
      repeat (H) @(negedge clk);
    end
    if (!keep_ss) begin
      ss       = 1'b1;
      rise_cyc = cyc;
      repeat (2 * H) @(negedge clk);
    end
  endtask

  task automatic frame_checks(input int nrx, input logic [15:0] rx_exp,
                              input int nur, input logic txr);
    check("rx_valid_count", rxv_count, nrx);
    for (int k = 0; k < nrx; k++) begin
      if (k < rx_seen.size()) check("rx_byte_seq", rx_seen[k], 8'(rx_exp >> (8 - 8 * k)));
    end
    check("underrun_count", urun_count, nur);
    check("tx_ready_after", tx_ready, txr);
    check("busy_after", busy, 1'b0);
  endtask

  initial begin
    logic [15:0] mi;
    bit [1:0] mb;

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    in_rst = 1'b0;
    @(negedge clk);
    check("reset_miso", miso, 1'b0);
    check("reset_tx_ready", tx_ready, 1'b1);
    check("reset_rx_byte", rx_byte, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_underrun", underrun, 1'b0);

    // All four modes: 0xA5 to master, 0x3C to slave.
    for (int m = 0; m < 4; m++) begin
      mb = 2'(m);
      clear_obs();
      load_byte(8'hA5);
      check("tx_ready_after_load", tx_ready, 1'b0);
      do_frame(mb[1], mb[0], 8, 16'h3C00, 1'b0, 1'b0, 8'h00, mi);
      check("master_rx_mode", mi[15:8], 8'hA5);
      check("rx_byte_mode", rx_byte, 8'h3C);
      frame_checks(1, 16'h3C00, exp_underruns(mb[0], 1, 1), 1'b1);
    end

    // Load while the buffer is full is ignored.
    clear_obs();
    load_byte(8'h11);
    load_byte(8'h22);
    do_frame(1'b0, 1'b0, 8, 16'h9600, 1'b0, 1'b0, 8'h00, mi);
    check("master_rx_full_ignore", mi[15:8], 8'h11);
    frame_checks(1, 16'h9600, exp_underruns(1'b0, 1, 1), 1'b1);

    // Two bytes in one frame, second byte loaded once the buffer drains.
    clear_obs();
    load_byte(8'h81);
    fork
      do_frame(1'b0, 1'b0, 16, 16'hC35A, 1'b0, 1'b0, 8'h00, mi);
      wait_ready_and_load(8'h7E);
    join
    check("master_rx_two_bytes", mi, 16'h817E);
    frame_checks(2, 16'hC35A, exp_underruns(1'b0, 2, 2), 1'b1);

    // No load at all: one underrun, zeros to master, rx still captured.
    clear_obs();
    do_frame(1'b0, 1'b1, 8, 16'h6900, 1'b0, 1'b0, 8'h00, mi);
    check("master_rx_underrun", mi[15:8], 8'h00);
    check("underrun_literal", urun_count, 1);
    frame_checks(1, 16'h6900, exp_underruns(1'b1, 1, 0), 1'b1);

    // ss raised after 5 bits: byte dropped, next frame clean.
    clear_obs();
    load_byte(8'h55);
    do_frame(1'b0, 1'b0, 5, 16'hFF00, 1'b0, 1'b0, 8'h00, mi);
    frame_checks(0, 16'h0000, 0, 1'b1);
    clear_obs();
    load_byte(8'hA5);
    do_frame(1'b0, 1'b0, 8, 16'h3C00, 1'b0, 1'b0, 8'h00, mi);
    check("master_rx_after_abort", mi[15:8], 8'hA5);
    frame_checks(1, 16'h3C00, exp_underruns(1'b0, 1, 1), 1'b1);

    // Load coinciding with the frame-start consume of an empty buffer.
    clear_obs();
    do_frame(1'b0, 1'b1, 8, 16'h0F00, 1'b0, 1'b1, 8'h5A, mi);
    check("master_rx_coincident", mi[15:8], 8'h00);
    frame_checks(1, 16'h0F00, 1, 1'b0);
    clear_obs();
    do_frame(1'b0, 1'b1, 8, 16'hF000, 1'b0, 1'b0, 8'h00, mi);
    check("master_rx_captured", mi[15:8], 8'h5A);
    frame_checks(1, 16'hF000, 0, 1'b1);

    // Reset after 3 bits of a mode-3 frame.
    clear_obs();
    load_byte(8'hA5);
    do_frame(1'b1, 1'b1, 3, 16'h3C00, 1'b1, 1'b0, 8'h00, mi);
    #2 rst = 1'b1;
    in_rst    = 1'b1;
    have_fall = 1'b0;
    #1;
    check("async_rst_miso", miso, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_tx_ready", tx_ready, 1'b1);
    @(negedge clk);
    ss       = 1'b1;
    rise_cyc = cyc;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    in_rst = 1'b0;
    check("rx_valid_count_rst", rxv_count, 0);
    clear_obs();
    load_byte(8'hA5);
    do_frame(1'b1, 1'b1, 8, 16'h3C00, 1'b0, 1'b0, 8'h00, mi);
    check("master_rx_after_rst", mi[15:8], 8'hA5);
    frame_checks(1, 16'h3C00, exp_underruns(1'b1, 1, 1), 1'b1);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000ns, required finish");
    $fatal(1);
  end

endmodule
